// File: rtl/main_mem_pkg.sv
// Shared types and sizes for the on-chip main memory
// and the blocks that stream data out of it.
package main_mem_pkg;

    localparam int MEM_ADDR_W     = 15;
    localparam int MEM_DATA_W     = 32;
    localparam int MEM_WORDS      = 32768;
    localparam int MEM_RD_LATENCY = 1;

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] mem_word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/main_mem_reader_fifo.sv
// Output skid FIFO for the main memory reader.
// Power-of-two depth, registered storage, occupancy count.
module main_mem_reader_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // Pop only real data; a push into a full FIFO is accepted only alongside a pop.
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != (AW+1)'(DEPTH)) || do_pop);
    end

    // Storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

    assign dout  = store[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/main_mem_reader.sv
// Avalon-MM read master streaming a block of main memory
// out as one Avalon-ST packet with full backpressure.
module main_mem_reader
    import main_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int RD_LATENCY = MEM_RD_LATENCY,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int NW = ADDR_W + 1;

    rd_state_t                   state;
    rd_state_t                   state_n;
    logic [NW-1:0]               cnt_q;
    logic [NW-1:0]               issued;
    logic [ADDR_W-1:0]           addr_q;
    logic [RD_LATENCY-1:0]       pipe_v;
    logic [RD_LATENCY-1:0][1:0]  pipe_tag;
    logic                        done_q;
    logic                        done_d;
    logic                        issue;
    logic                        last_rd;
    logic [CW-1:0]               inflight;
    logic [CW:0]                 occ;
    logic [CW-1:0]               fifo_count;
    logic                        fifo_empty;
    logic [DATA_W+1:0]           fifo_dout;

    // Reads in flight plus FIFO contents bound the credit for new reads.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_v[i]);
        end
        occ     = {1'b0, fifo_count} + {1'b0, inflight};
        last_rd = (issued == cnt_q - NW'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, read issue and done request.
    always_comb begin
        state_n = state;
        done_d  = 1'b0;
        issue   = 1'b0;
        busy    = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                issue = (issued < cnt_q) && (occ < (CW+1)'(FIFO_DEPTH));
                if (issue && last_rd) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (st_valid && st_ready && st_eop) begin
                    state_n = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Transfer counters, address and the sop/eop-tagged in-flight pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            issued   <= '0;
            pipe_v   <= '0;
            pipe_tag <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            if (state == IDLE && start) begin
                addr_q <= base_addr;
                cnt_q  <= word_count;
                issued <= '0;
            end
            if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);
                issued <= issued + NW'(1);
            end
            pipe_v[0]   <= issue;
            pipe_tag[0] <= {issued == '0, last_rd};
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    main_mem_reader_fifo #(
        .W     (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pipe_v[RD_LATENCY-1]),
        .din   ({mem_readdata, pipe_tag[RD_LATENCY-1]}),
        .pop   (st_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign st_valid       = !fifo_empty;
    assign st_data        = fifo_dout[DATA_W+1:2];
    assign st_sop         = fifo_dout[1] & st_valid;
    assign st_eop         = fifo_dout[0] & st_valid;

endmodule

// File: tb/tb_main_mem_reader.sv
// Scoreboard bench for main_mem_reader: expected beats and
// read addresses are queued at start, a monitor pops and compares.
module tb_main_mem_reader;
    import main_mem_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done;
    logic [14:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = '0;
    logic [31:0] st_data;
    logic        st_valid, st_sop, st_eop;
    logic        st_ready = 1'b1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int mode = 0;
    int rd_cnt = 0;
    int beats = 0;
    int done_cnt = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    int start_cyc = 0;
    beat_t       q[$];
    logic [14:0] aq[$];

    main_mem_reader dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [14:0] a);
        return {a, 2'b10, a} ^ 32'h5A5A_0000;
    endfunction

    // One-cycle latency memory model.
    always @(posedge clk) mem_readdata <= mem_val(mem_address);

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready pattern: 0 always ready, 1 random, 2 stalled.
    initial forever begin
        @(posedge clk);
        #1;
        case (mode)
            1: st_ready = 1'($urandom_range(0, 1));
            2: st_ready = 1'b0;
            default: st_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: read addresses, stream beats, done pulses.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (mem_chipselect) begin
                rd_cnt++;
                if (aq.size() == 0) chk("extra_read", {49'h0, mem_address}, 64'hFFFF);
                else chk("read_addr", {49'h0, mem_address}, {49'h0, aq.pop_front()});
            end
            if (st_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (q.size() == 0) chk("extra_beat", {30'h0, st_data, st_sop, st_eop}, '1);
                else chk("beat", {30'h0, st_data, st_sop, st_eop}, {30'h0, q[0]});
                if (st_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    beats++;
                    last_cyc = cyc;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic prep();
        rd_cnt = 0;
        beats = 0;
        done_cnt = 0;
        first_cyc = -1;
    endtask

    task automatic pulse(input logic [14:0] b, input logic [15:0] n);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        word_count = n;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic xfer(input logic [14:0] b, input int n);
        logic [14:0] a;
        prep();
        for (int i = 0; i < n; i++) begin
            a = b + 15'(i);
            q.push_back('{mem_val(a), i == 0, i == n - 1});
            aq.push_back(a);
        end
        pulse(b, 16'(n));
    endtask

    task automatic wait_done(input string name, input int maxc);
        int n = 0;
        while (done_cnt == 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_timeout"}, 64'(n < maxc), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({name, "_left"}, 64'(q.size() + aq.size()), 64'd0);
        chk({name, "_busy"}, {63'h0, busy}, 64'd0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_outs"}, {58'h0, busy, done, mem_chipselect, st_valid, st_sop, st_eop}, 64'd0);
        chk({name, "_addr"}, {49'h0, mem_address}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        chk("ties", {57'h0, mem_write, mem_byteenable, mem_clken}, {57'h0, 1'b0, 4'hF, 1'b1});
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic 4-word packet, latency and back-to-back beats.
        xfer(15'h0010, 4);
        wait_done("basic", 100);
        chk("first_latency", 64'(first_cyc - start_cyc), 64'd3);
        chk("back_to_back", 64'(last_cyc - first_cyc), 64'd3);

        // Address wrap at the top of memory.
        xfer(15'h7FFE, 4);
        wait_done("wrap", 100);
        chk("wrap_reads", 64'(rd_cnt), 64'd4);

        // Random backpressure.
        mode = 1;
        xfer(15'h0800, 16);
        wait_done("random", 1000);
        chk("random_beats", 64'(beats), 64'd16);
        mode = 0;

        // FIFO full: reads stop at FIFO_DEPTH until ready returns.
        mode = 2;
        @(posedge clk);
        xfer(15'h0100, 16);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_reads", 64'(rd_cnt), 64'd4);
        chk("stall_cs", {63'h0, mem_chipselect}, 64'd0);
        chk("stall_beats", 64'(beats), 64'd0);
        mode = 0;
        wait_done("stall", 200);

        // Zero-length start.
        prep();
        pulse(15'h0123, 16'd0);
        @(negedge clk);
        chk("zero_done", {63'h0, done}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("zero_activity", 64'(rd_cnt + beats), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);

        // Single-word packet.
        xfer(15'h0555, 1);
        wait_done("one", 100);

        // Full memory packet.
        xfer(15'h1234, MEM_WORDS);
        wait_done("full", 40000);
        chk("full_beats", 64'(beats), 64'(MEM_WORDS));

        // Reset mid-transfer drops everything.
        mode = 2;
        @(posedge clk);
        xfer(15'h0300, 16);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        aq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_no_done", 64'(done_cnt), 64'd0);

        // A start while busy is ignored.
        mode = 2;
        @(posedge clk);
        xfer(15'h0040, 4);
        pulse(15'h0200, 16'd8);
        mode = 0;
        wait_done("ignored", 200);
        repeat (10) @(posedge clk);
        #1;
        chk("ignored_reads", 64'(rd_cnt), 64'd4);
        chk("ignored_beats", 64'(beats), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
